// File: rtl/alu_sequencer.sv
// Four-phase register-file sequencer (IDLE/READ/EXEC/WB) that feeds an external
// combinational ALU and writes the result back with {N,Z,P} condition codes.
module alu_sequencer #(
  parameter int IMM_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_dr,
  input  logic [2:0]       cmd_sr1,
  input  logic [2:0]       cmd_sr2,
  input  logic             cmd_imm_sel,
  input  logic [IMM_W-1:0] cmd_imm,
  input  logic             ld_en,
  input  logic [2:0]       ld_addr,
  input  logic [15:0]      ld_data,
  output logic [15:0]      alu_A,
  output logic [15:0]      alu_B,
  output logic [1:0]       alu_select,
  input  logic [15:0]      alu_out,
  output logic             done,
  output logic [15:0]      result,
  output logic [2:0]       nzp,
  input  logic [2:0]       rd_addr,
  output logic [15:0]      rd_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [2:0]         dr_q, dr_d, sr1_q, sr1_d, sr2_q, sr2_d;
  logic               imm_sel_q, imm_sel_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [15:0]        a_q, a_d, b_q, b_d;
  logic [15:0]        result_q, result_d;
  logic [2:0]         nzp_q, nzp_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [1:0]         alu_select_q, alu_select_d;
  logic [15:0]        regs_q [8];
  logic [15:0]        regs_d [8];

  function automatic logic [15:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(16-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [2:0] cond_codes(input logic [15:0] v);
    logic [2:0] c;
    if (v[15]) begin
      c = 3'b100;
    end else if (v == 16'h0000) begin
      c = 3'b010;
    end else begin
      c = 3'b001;
    end
    return c;
  endfunction

  // Next-state, register-file and output computation for every phase.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dr_d      = dr_q;
    sr1_d     = sr1_q;
    sr2_d     = sr2_q;
    imm_sel_d = imm_sel_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    nzp_d     = nzp_q;
    done_d    = 1'b0;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        // A load coinciding with accept lands before READ samples the file.
        if (ld_en) begin
          regs_d[ld_addr] = ld_data;
        end else begin
          regs_d = regs_q;
        end
        if (cmd_valid) begin
          op_d      = cmd_op;
          dr_d      = cmd_dr;
          sr1_d     = cmd_sr1;
          sr2_d     = cmd_sr2;
          imm_sel_d = cmd_imm_sel;
          imm_d     = cmd_imm;
          state_d   = READ;
        end else begin
          state_d   = IDLE;
        end
      end
      READ: begin
        a_d = regs_q[sr1_q];
        if (imm_sel_q) begin
          b_d = sext_imm(imm_q);
        end else begin
          b_d = regs_q[sr2_q];
        end
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_out;
        done_d   = 1'b1;
        state_d  = WB;
      end
      WB: begin
        regs_d[dr_q] = result_q;
        nzp_d        = cond_codes(result_q);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    if (state_d == EXEC) begin
      alu_select_d = op_d;
    end else begin
      alu_select_d = 2'b11;
    end
  end

  // All sequencer state, with asynchronous clear of the register file.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      dr_q         <= 3'b000;
      sr1_q        <= 3'b000;
      sr2_q        <= 3'b000;
      imm_sel_q    <= 1'b0;
      imm_q        <= '0;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      result_q     <= 16'h0000;
      nzp_q        <= 3'b000;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      alu_select_q <= 2'b11;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dr_q         <= dr_d;
      sr1_q        <= sr1_d;
      sr2_q        <= sr2_d;
      imm_sel_q    <= imm_sel_d;
      imm_q        <= imm_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      nzp_q        <= nzp_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      alu_select_q <= alu_select_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_select = alu_select_q;
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign done       = done_q;
  assign result     = result_q;
  assign nzp        = nzp_q;
  assign rd_data    = regs_q[rd_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized commands against a behavioural model.
`timescale 1ns/100ps
module tb_alu_sequencer;
  localparam int IMM_W = 5;

  logic             Clk;
  logic             Reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_dr, cmd_sr1, cmd_sr2;
  logic             cmd_imm_sel;
  logic [IMM_W-1:0] cmd_imm;
  logic             ld_en;
  logic [2:0]       ld_addr;
  logic [15:0]      ld_data;
  logic [15:0]      alu_A, alu_B;
  logic [1:0]       alu_select;
  logic [15:0]      alu_out;
  logic             done;
  logic [15:0]      result;
  logic [2:0]       nzp;
  logic [2:0]       rd_addr;
  logic [15:0]      rd_data;

  alu_sequencer #(.IMM_W(IMM_W)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dr(cmd_dr), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .alu_A(alu_A), .alu_B(alu_B), .alu_select(alu_select),
    .alu_out(alu_out), .done(done), .result(result), .nzp(nzp),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // External combinational ALU
  always_comb begin
    case (alu_select)
      2'b00:   alu_out = alu_A + alu_B;
      2'b01:   alu_out = alu_A & alu_B;
      2'b10:   alu_out = ~alu_A;
      default: alu_out = alu_A;
    endcase
  end

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] ref_r [8];
  logic [2:0]  ref_nzp;

  typedef struct {
    bit          is_load;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  op;
    logic [2:0]  dr, sr1, sr2;
    logic        isel;
    logic [4:0]  imm;
    logic [15:0] exp_val;
    logic [2:0]  exp_nzp;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a & b;
    if (op == 2'd2) return ~a;
    return a;
  endfunction

  function automatic logic [2:0] model_nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk(name, rd_data, ref_r[i]);
    end
  endtask

  task automatic do_load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge Clk);
    @(negedge Clk);
    ld_en = 1'b0;
    ref_r[a] = d;
  endtask

  // Runs one command from an IDLE negedge, checking every phase; returns result.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] dr, input logic [2:0] sr1,
                        input logic [2:0] sr2, input logic isel, input logic [4:0] imm,
                        input logic ld, input logic [2:0] la, input logic [15:0] ldd,
                        input logic wb_ld, output logic [15:0] res);
    logic [15:0] a, b;
    chk("idle_ready", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dr = dr; cmd_sr1 = sr1; cmd_sr2 = sr2;
    cmd_imm_sel = isel; cmd_imm = imm;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    if (ld) ref_r[la] = ldd;
    a = ref_r[sr1];
    b = isel ? 16'($signed(imm)) : ref_r[sr2];
    res = model_op(op, a, b);
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0; ld_en = 1'b0;
    cmd_op = 2'($urandom); cmd_dr = 3'($urandom); cmd_sr1 = 3'($urandom);
    cmd_sr2 = 3'($urandom); cmd_imm = 5'($urandom); cmd_imm_sel = 1'($urandom);
    chk("read_done", 16'(done), 16'd0);
    chk("read_ready", 16'(cmd_ready), 16'd0);
    chk("read_sel", 16'(alu_select), 16'd3);
    @(negedge Clk);
    chk("exec_sel", 16'(alu_select), 16'(op));
    chk("exec_A", alu_A, a);
    if (op < 2'd2) chk("exec_B", alu_B, b);
    chk("exec_done", 16'(done), 16'd0);
    @(negedge Clk);
    chk("wb_done", 16'(done), 16'd1);
    chk("wb_result", result, res);
    chk("wb_sel", 16'(alu_select), 16'd3);
    if (wb_ld) begin
      ld_en = 1'b1; ld_addr = 3'($urandom); ld_data = 16'($urandom);
    end
    @(negedge Clk);
    ld_en = 1'b0;
    ref_r[dr] = res;
    ref_nzp = model_nzp(res);
    chk("idle_done", 16'(done), 16'd0);
    chk("idle_ready2", 16'(cmd_ready), 16'd1);
    chk("nzp", 16'(nzp), 16'(ref_nzp));
    check_regs("regs");
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
    ref_nzp = 3'b000;
  endtask

  vec_t vecs [9];
  logic [15:0] r;
  int acc_cyc [3];
  int n_acc;

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dr = 3'd0; cmd_sr1 = 3'd0; cmd_sr2 = 3'd0;
    cmd_imm_sel = 1'b0; cmd_imm = 5'd0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'd0;
    rd_addr = 3'd0;
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
    ref_nzp = 3'b000;
    #5;
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_sel", 16'(alu_select), 16'd3);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'd0);
    chk("rst_nzp", 16'(nzp), 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    check_regs("rst_regs");

    vecs[0] = '{1'b1, 3'd1, 16'h7FFF, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 5'd0, 16'h7FFF, 3'b000};
    vecs[1] = '{1'b1, 3'd2, 16'h0001, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 5'd0, 16'h0001, 3'b000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 5'd0, 16'h8000, 3'b100};
    vecs[3] = '{1'b1, 3'd1, 16'h00F0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 5'd0, 16'h00F0, 3'b000};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 2'd1, 3'd4, 3'd1, 3'd0, 1'b1, 5'b10000, 16'h00F0, 3'b001};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 2'd1, 3'd4, 3'd1, 3'd0, 1'b1, 5'b01111, 16'h0000, 3'b010};
    vecs[6] = '{1'b1, 3'd5, 16'hFFFF, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 5'd0, 16'hFFFF, 3'b000};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 2'd2, 3'd5, 3'd5, 3'd0, 1'b0, 5'd0, 16'h0000, 3'b010};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 2'd3, 3'd6, 3'd1, 3'd0, 1'b0, 5'd0, 16'h00F0, 3'b001};

    foreach (vecs[i]) begin
      if (vecs[i].is_load) begin
        do_load(vecs[i].addr, vecs[i].data);
        rd_addr = vecs[i].addr;
        #1;
        chk("vec_load", rd_data, vecs[i].exp_val);
      end else begin
        do_cmd(vecs[i].op, vecs[i].dr, vecs[i].sr1, vecs[i].sr2, vecs[i].isel, vecs[i].imm,
               1'b0, 3'd0, 16'd0, 1'b0, r);
        chk("vec_result", r, vecs[i].exp_val);
        chk("vec_nzp", 16'(nzp), 16'(vecs[i].exp_nzp));
      end
    end

    // Load coinciding with accept: READ must see the loaded value, R2 = R7 + R7.
    do_cmd(2'd0, 3'd2, 3'd7, 3'd7, 1'b0, 5'd0, 1'b1, 3'd7, 16'h1111, 1'b0, r);
    chk("ld_accept", r, 16'h2222);

    // Back-to-back ADD R1 = R1 + 1 with cmd_valid held high from a clean reset.
    reset_dut();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dr = 3'd1; cmd_sr1 = 3'd1; cmd_sr2 = 3'd0;
    cmd_imm_sel = 1'b1; cmd_imm = 5'd1;
    n_acc = 0;
    for (int cyc = 0; cyc < 20 && n_acc < 3; cyc++) begin
      if (n_acc > 0 && cyc == acc_cyc[0] + 2) begin
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h5555;
      end else begin
        ld_en = 1'b0;
      end
      if (cmd_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (n_acc < 3) @(negedge Clk);
    end
    chk("b2b_accepts", 16'(n_acc), 16'd3);
    @(posedge Clk);
    #1 cmd_valid = 1'b0; ld_en = 1'b0;
    if (n_acc == 3) begin
      chk("b2b_gap1", 16'(acc_cyc[1] - acc_cyc[0]), 16'd4);
      chk("b2b_gap2", 16'(acc_cyc[2] - acc_cyc[1]), 16'd4);
    end
    repeat (4) @(negedge Clk);
    ref_r[1] = 16'd3;
    ref_nzp = 3'b001;
    chk("b2b_nzp", 16'(nzp), 16'(ref_nzp));
    check_regs("b2b_regs");

    // Reset during EXEC of ADD dr=2.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dr = 3'd2; cmd_sr1 = 3'd1; cmd_sr2 = 3'd1;
    cmd_imm_sel = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
    @(negedge Clk);
    chk("pre_rst_exec", 16'(alu_select), 16'd0);
    Reset = 1'b1;
    #1;
    chk("midrst_ready", 16'(cmd_ready), 16'd1);
    chk("midrst_sel", 16'(alu_select), 16'd3);
    chk("midrst_A", alu_A, 16'd0);
    chk("midrst_nzp", 16'(nzp), 16'd0);
    chk("midrst_result", result, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0;
    ref_nzp = 3'b000;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_nodone", 16'(done), 16'd0);
      @(negedge Clk);
    end
    check_regs("midrst_regs");

    // Randomized commands, loads, and ignored loads during WB.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(3'($urandom), ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h8000);
      end
      do_cmd(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
             5'($urandom), ($urandom_range(0, 4) == 0), 3'($urandom), 16'($urandom),
             1'($urandom), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter IMM_W, default 5: immediate field width, sign-extended to 16 bits.
REQ-002 The block SHALL have port Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid at a rising edge.
REQ-006 The block SHALL have port cmd_op  input  2  operation: 00 ADD, 01 AND, 10 NOT, 11 PASS_A.
REQ-007 The block SHALL have ports cmd_dr, cmd_sr1, cmd_sr2  input  3 each  destination and source register indices.
REQ-008 The block SHALL have port cmd_imm_sel  input  1  when high, operand B is the sign-extended cmd_imm instead of R[sr2].
REQ-009 The block SHALL have port cmd_imm  input  IMM_W  immediate operand.
REQ-010 The block SHALL have ports ld_en (input, 1), ld_addr (input, 3) and ld_data (input, 16): direct register load.
REQ-011 The block SHALL have ports alu_A, alu_B (output, 16 each) and alu_select (output, 2): drive to the external ALU.
REQ-012 The block SHALL have port alu_out  input  16  combinational ALU result.
REQ-013 The block SHALL have ports done (output, 1), result (output, 16) and nzp (output, 3): completion pulse, last result, condition codes {N,Z,P}.
REQ-014 The block SHALL have ports rd_addr (input, 3) and rd_data (output, 16): asynchronous debug read of R[rd_addr].

Function
REQ-015 The block SHALL contain an 8 x 16-bit register file R0-R7 and a four-state FSM: IDLE, READ, EXEC, WB.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted at a rising edge with IDLE and cmd_valid=1, and op, dr, sr1, sr2, imm_sel and imm SHALL be latched on that edge.
REQ-017 Transitions: IDLE->READ on accept; READ->EXEC, EXEC->WB and WB->IDLE unconditionally; IDLE SHALL hold while cmd_valid=0.
REQ-018 READ SHALL latch A=R[sr1], and B=SEXT(imm) if imm_sel else R[sr2], into internal operand registers.
REQ-019 alu_A and alu_B SHALL reflect the operand registers at all times, and alu_select SHALL equal the latched op in EXEC and 2'b11 in all other states.
REQ-020 At the EXEC->WB edge, alu_out SHALL be captured into result.
REQ-021 At the WB->IDLE edge, R[dr] SHALL be written with result and nzp SHALL be updated: 100 if result[15]=1, 010 if result=0, else 001.
REQ-022 done SHALL be high for exactly the WB cycle.
REQ-023 Latency: for a command accepted at edge k, done SHALL be high in the cycle after edge k+2, the R[dr] write SHALL occur at edge k+3, and the next accept SHALL be possible at edge k+4 at the earliest.
REQ-024 NOT and PASS_A SHALL ignore B, and cmd_sr2 and cmd_imm are don't-care for those ops.
REQ-025 ADD SHALL wrap modulo 2^16 with no carry or overflow flag.
REQ-026 ld_en SHALL write R[ld_addr]=ld_data only in IDLE and SHALL be ignored in READ, EXEC and WB.
REQ-027 When ld_en and a command accept coincide in IDLE, the load SHALL take effect and the READ state SHALL see the loaded value.
REQ-028 When sr1 or sr2 equals dr, READ SHALL use the pre-write value.
REQ-029 cmd_valid held high continuously SHALL issue back-to-back commands every 4 cycles, with each command observing the previous write-back.
REQ-030 rd_data SHALL reflect a write on the cycle after the write edge.

Reset
REQ-031 Reset asserted at any time, including mid-command, SHALL immediately force state=IDLE, R0-R7=0, operand registers=0, result=0, nzp=000, done=0, cmd_ready=1 and alu_select=11.
REQ-032 A command interrupted by Reset SHALL perform no register write.
REQ-033 After Reset deasserts, the first rising edge with cmd_valid=1 SHALL accept a command.

Verification
REQ-034 The bench SHALL cover: load R1=0x7FFF, R2=0x0001, then ADD dr=3, sr1=1, sr2=2 -> done 3 cycles after accept, R3=0x8000, nzp=100.
REQ-035 The bench SHALL cover: R1=0x00F0, AND dr=4, sr1=1, imm=5'b10000 (0xFFF0) -> R4=0x00F0, nzp=001; with imm=5'b01111 -> R4=0x0000, nzp=010.
REQ-036 The bench SHALL cover: R5=0xFFFF, NOT dr=5, sr1=5 -> R5=0x0000, nzp=010; PASS_A dr=6, sr1=1 -> R6=R1.
REQ-037 The bench SHALL cover: cmd_valid held high for 3 ADD R1=R1+imm 1 commands from R1=0 -> accepts 4 cycles apart, final R1=3, and ld_en pulsed during EXEC ignored.
REQ-038 The bench SHALL cover: Reset asserted during EXEC of ADD dr=2 -> all registers 0, done never pulses, cmd_ready=1 immediately.
